// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters,
// with optional zero-fill after reset and read-response routing by requester id.
`timescale 1ns/1ps
module bram_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int RAM_WIDTH     = 18,
  parameter int RAM_DEPTH     = 1024,
  parameter int RD_LATENCY    = 2,
  parameter int INIT_ON_RESET = 1,
  localparam int AW           = $clog2(RAM_DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_val,
  input  logic [NUM_REQ-1:0]             i_req_we,
  input  logic [NUM_REQ*AW-1:0]          i_req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   i_req_d,
  output logic [NUM_REQ-1:0]             o_req_rdy,
  output logic [NUM_REQ-1:0]             o_rsp_val,
  output logic [RAM_WIDTH-1:0]           o_rsp_q,
  output logic [AW-1:0]                  o_ram_a,
  output logic                           o_ram_en,
  output logic                           o_ram_we,
  output logic                           o_ram_re,
  output logic [RAM_WIDTH-1:0]           o_ram_d,
  input  logic [RAM_WIDTH-1:0]           i_ram_q,
  output logic                           o_init_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = IW + 1;
  localparam int NW = AW + 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [NW-1:0]         r_cnt;
  logic                  w_init_wr;
  logic                  w_init_last;
  logic                  r_init_done;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         w_ptr_next;
  logic [IW-1:0]         w_gnt_idx;
  logic                  w_gnt_vld;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [AW-1:0]         w_addr [NUM_REQ];
  logic [RAM_WIDTH-1:0]  w_data [NUM_REQ];
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [AW-1:0]         r_ram_a;
  logic [RAM_WIDTH-1:0]  r_ram_d;
  logic                  r_ram_rd;
  logic [NUM_REQ-1:0]    r_ram_id;
  logic [RD_LATENCY-1:0] r_sh_vld;
  logic [NUM_REQ-1:0]    r_sh_id [RD_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi] = i_req_addr[gi*AW +: AW];
      assign w_data[gi] = i_req_d[gi*RAM_WIDTH +: RAM_WIDTH];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (w_init_last) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // Counter runs one past the last address so the final write is on the port
  // for a full cycle before RUN begins.
  always_comb begin
    w_init_wr   = 1'b0;
    w_init_last = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_wr   = (r_cnt != NW'(RAM_DEPTH));
        w_init_last = (r_cnt == NW'(RAM_DEPTH));
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_cnt <= '0;
    else if (w_init_wr) r_cnt <= r_cnt + NW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_init_done <= 1'b0;
    else       r_init_done <= (w_state_next == ST_RUN);
  end

  // Search downward so the candidate closest to r_ptr is the last to win.
  always_comb begin
    logic [CW-1:0] cand;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, r_ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (i_req_val[cand[IW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign w_accept = r_init_done & w_gnt_vld;

  always_comb begin
    w_gnt_oh = '0;
    if (w_accept) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_accept)
      w_ptr_next = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_ptr <= '0;
    else       r_ptr <= w_ptr_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_a  <= '0;
      r_ram_d  <= '0;
      r_ram_rd <= 1'b0;
      r_ram_id <= '0;
    end else if (w_init_wr) begin
      r_ram_en <= 1'b1;
      r_ram_we <= 1'b1;
      r_ram_a  <= r_cnt[AW-1:0];
      r_ram_d  <= '0;
      r_ram_rd <= 1'b0;
    end else if (w_accept) begin
      r_ram_en <= 1'b1;
      r_ram_we <= i_req_we[w_gnt_idx];
      r_ram_a  <= w_addr[w_gnt_idx];
      r_ram_d  <= w_data[w_gnt_idx];
      r_ram_rd <= ~i_req_we[w_gnt_idx];
      r_ram_id <= w_gnt_oh;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_rd <= 1'b0;
    end
  end

  // Tag pipeline: stage 0 aligns with the cycle after the port is driven.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_sh_id[i] <= '0;
    end else begin
      r_sh_vld[0] <= r_ram_rd;
      r_sh_id[0]  <= r_ram_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sh_vld[i] <= r_sh_vld[i-1];
        r_sh_id[i]  <= r_sh_id[i-1];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_re_outreg
      assign o_ram_re = r_sh_vld[0];
    end else begin : g_re_none
      assign o_ram_re = 1'b0;
    end
  endgenerate

  assign o_req_rdy   = w_gnt_oh;
  assign o_rsp_val   = r_sh_vld[RD_LATENCY-1] ? r_sh_id[RD_LATENCY-1] : '0;
  assign o_rsp_q     = i_ram_q;
  assign o_ram_en    = r_ram_en;
  assign o_ram_we    = r_ram_we;
  assign o_ram_a     = r_ram_a;
  assign o_ram_d     = r_ram_d;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM plus a round-robin/scoreboard reference model.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

  localparam int NR = 4;
  localparam int W  = 18;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] val = '0, we = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*W-1:0]  d = '0;
  logic [NR-1:0] a_rdy, a_rsp_val;
  logic [W-1:0]  a_rsp_q, a_ram_d, a_ram_q;
  logic [AW-1:0] a_ram_a;
  logic          a_ram_en, a_ram_we, a_ram_re, a_done;

  logic          rst_b = 1'b1;
  logic [NR-1:0] b_val = '0, b_we = '0;
  logic [NR*AW-1:0] b_addr = '0;
  logic [NR*W-1:0]  b_d = '0;
  logic [NR-1:0] b_rdy, b_rsp_val;
  logic [W-1:0]  b_rsp_q, b_ram_d, b_ram_q;
  logic [AW-1:0] b_ram_a;
  logic          b_ram_en, b_ram_we, b_ram_re, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.NUM_REQ(NR), .RAM_WIDTH(W), .RAM_DEPTH(DP),
                      .RD_LATENCY(2), .INIT_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_val(val), .i_req_we(we), .i_req_addr(addr),
    .i_req_d(d), .o_req_rdy(a_rdy), .o_rsp_val(a_rsp_val), .o_rsp_q(a_rsp_q),
    .o_ram_a(a_ram_a), .o_ram_en(a_ram_en), .o_ram_we(a_ram_we), .o_ram_re(a_ram_re),
    .o_ram_d(a_ram_d), .i_ram_q(a_ram_q), .o_init_done(a_done));

  bram_port_arbiter #(.NUM_REQ(NR), .RAM_WIDTH(W), .RAM_DEPTH(DP),
                      .RD_LATENCY(1), .INIT_ON_RESET(0)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_req_val(b_val), .i_req_we(b_we), .i_req_addr(b_addr),
    .i_req_d(b_d), .o_req_rdy(b_rdy), .o_rsp_val(b_rsp_val), .o_rsp_q(b_rsp_q),
    .o_ram_a(b_ram_a), .o_ram_en(b_ram_en), .o_ram_we(b_ram_we), .o_ram_re(b_ram_re),
    .o_ram_d(b_ram_d), .i_ram_q(b_ram_q), .o_init_done(b_done));

  // Behavioural RAMs: A has an output register (latency 2), B is low-latency.
  logic [W-1:0] mem_a [DP];
  logic [W-1:0] lat_a, qreg_a;
  always @(posedge clk) begin
    if (a_ram_en) begin
      if (a_ram_we) mem_a[a_ram_a] <= a_ram_d;
      else          lat_a <= mem_a[a_ram_a];
    end
    if (a_ram_re) qreg_a <= lat_a;
  end
  assign a_ram_q = qreg_a;

  logic [W-1:0] mem_b [DP];
  logic [W-1:0] lat_b;
  always @(posedge clk) begin
    if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_a] <= b_ram_d;
      else          lat_b <= mem_b[b_ram_a];
    end
  end
  assign b_ram_q = lat_b;

  // Reference model state for DUT A
  typedef struct { int due; int id; logic [W-1:0] q; } rsp_t;
  rsp_t         pend[$];
  logic [W-1:0] m_mem [DP];
  int           m_ptr, cyc;
  logic         m_en, m_we, m_re, m_rd_last;
  logic [AW-1:0] m_a;
  logic [W-1:0]  m_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [W-1:0] dd);
    val[k] = v;
    we[k]  = w;
    addr[k*AW +: AW] = a;
    d[k*W +: W] = dd;
  endtask

  function automatic int exp_grant(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++)
      if (v[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    m_ptr = 0; m_en = 1'b0; m_we = 1'b0; m_re = 1'b0; m_rd_last = 1'b0;
    m_a = AW'(DP - 1); m_d = '0;
  endtask

  // Zero-fill: called right after the first clock edge with reset low is pending.
  task automatic init_phase();
    val = '1;
    for (int i = 0; i < DP; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("init_en",   32'(a_ram_en), 32'd1);
      chk("init_we",   32'(a_ram_we), 32'd1);
      chk("init_addr", 32'(a_ram_a), 32'(i));
      chk("init_data", 32'(a_ram_d), 32'd0);
      chk("init_rdy",  32'(a_rdy), 32'd0);
      chk("init_rsp",  32'(a_rsp_val), 32'd0);
      chk("init_done_low", 32'(a_done), 32'd0);
    end
    @(posedge clk); #1;
    val = '0;
    model_reset();
  endtask

  task automatic run_cycle();
    int g;
    logic [NR-1:0] exp_rdy, exp_rsp;
    logic [AW-1:0] ga;
    logic [W-1:0]  gd, exp_q;
    @(negedge clk);
    chk("init_done", 32'(a_done), 32'd1);
    chk("ram_en", 32'(a_ram_en), 32'(m_en));
    chk("ram_we", 32'(a_ram_we), 32'(m_we));
    chk("ram_a",  32'(a_ram_a), 32'(m_a));
    chk("ram_d",  32'(a_ram_d), 32'(m_d));
    chk("ram_re", 32'(a_ram_re), 32'(m_re));
    g = exp_grant(val, m_ptr);
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_rdy", 32'(a_rdy), 32'(exp_rdy));
    exp_rsp = '0;
    exp_q   = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rsp = NR'(1 << pend[0].id);
      exp_q   = pend[0].q;
    end
    chk("rsp_val", 32'(a_rsp_val), 32'(exp_rsp));
    if (exp_rsp != '0) begin
      chk("rsp_q", 32'(a_rsp_q), 32'(exp_q));
      void'(pend.pop_front());
    end
    m_re = m_rd_last;
    m_rd_last = 1'b0;
    if (g >= 0) begin
      ga = addr[g*AW +: AW];
      gd = d[g*W +: W];
      m_en = 1'b1; m_we = we[g]; m_a = ga; m_d = gd;
      if (we[g]) m_mem[ga] = gd;
      else begin
        pend.push_back('{due: cyc + 3, id: g, q: m_mem[ga]});
        m_rd_last = 1'b1;
      end
      m_ptr = (g + 1) % NR;
    end else begin
      m_en = 1'b0;
      m_we = 1'b0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    model_reset();
    // Reset values, with all requests asserted to show grants stay off
    val = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  32'(a_rdy), 32'd0);
    chk("rst_rsp",  32'(a_rsp_val), 32'd0);
    chk("rst_en",   32'(a_ram_en), 32'd0);
    chk("rst_we",   32'(a_ram_we), 32'd0);
    chk("rst_re",   32'(a_ram_re), 32'd0);
    chk("rst_a",    32'(a_ram_a), 32'd0);
    chk("rst_d",    32'(a_ram_d), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_phase();

    // Fresh memory reads back as zero; first grant right after init
    set_req(1, 1'b1, 1'b0, 4'd9, '0);
    run_cycle();
    set_req(1, 1'b0, 1'b0, 4'd0, '0);
    set_req(3, 1'b1, 1'b0, 4'd15, '0);
    run_cycle();
    val = '0;
    repeat (4) run_cycle();

    // Write by requester 2 then read-after-write by requester 0
    set_req(2, 1'b1, 1'b1, 4'd7, 18'h2A5);
    run_cycle();
    val = '0;
    set_req(0, 1'b1, 1'b0, 4'd7, '0);
    run_cycle();
    val = '0;
    repeat (4) run_cycle();

    // Seed addresses 0..3 then all four requesters read them continuously
    for (int k = 0; k < NR; k++) begin
      val = '0;
      set_req(k, 1'b1, 1'b1, AW'(k), W'(18'h100 + k));
      run_cycle();
    end
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b0, AW'(k), '0);
    repeat (12) run_cycle();
    val = '0;
    repeat (4) run_cycle();

    // Single requester holding val is granted every cycle
    set_req(3, 1'b1, 1'b0, 4'd2, '0);
    repeat (10) run_cycle();
    val = '0;
    repeat (4) run_cycle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      val  = NR'($urandom);
      we   = NR'($urandom);
      addr = NR*AW'($urandom);
      for (int k = 0; k < NR; k++) d[k*W +: W] = W'($urandom);
      run_cycle();
    end
    val = '0;
    repeat (5) run_cycle();
    chk("drain_empty", 32'(pend.size()), 32'd0);

    // Reset with two reads in flight: no responses, INIT restarts at 0
    set_req(0, 1'b1, 1'b0, 4'd1, '0);
    set_req(1, 1'b1, 1'b0, 4'd2, '0);
    run_cycle();
    run_cycle();
    val = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    init_phase();
    set_req(2, 1'b1, 1'b0, 4'd7, '0);
    run_cycle();
    val = '0;
    repeat (4) run_cycle();
    chk("post_reset_empty", 32'(pend.size()), 32'd0);

    // DUT B: low-latency RAM, no zero-fill
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_rst_done", 32'(b_done), 32'd0);
    chk("b_rst_rsp",  32'(b_rsp_val), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_done", 32'(b_done), 32'd1);
    b_val = 4'b0010; b_we = 4'b0010;
    b_addr[1*AW +: AW] = 4'd3;
    b_d[1*W +: W] = 18'h155;
    @(negedge clk);
    chk("b_rdy_wr", 32'(b_rdy), 32'b0010);
    @(posedge clk); #1;
    b_val = 4'b0001; b_we = 4'b0000;
    b_addr[0*AW +: AW] = 4'd3;
    @(negedge clk);
    chk("b_rdy_rd", 32'(b_rdy), 32'b0001);
    chk("b_re_0",   32'(b_ram_re), 32'd0);
    @(posedge clk); #1;
    b_val = '0;
    @(negedge clk);
    chk("b_rsp_early", 32'(b_rsp_val), 32'd0);
    chk("b_re_1",      32'(b_ram_re), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_rsp_val", 32'(b_rsp_val), 32'b0001);
    chk("b_rsp_q",   32'(b_rsp_q), 32'h155);
    chk("b_re_2",    32'(b_ram_re), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_rsp_after", 32'(b_rsp_val), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of a true-dual-port block RAM among `NUM_REQ` requesters. It optionally zero-fills the whole memory after reset. It tracks read latency so each read response returns to the requester that issued it. The block sits between client logic (e.g. multi-stage pipelines sharing a lookup table) and the `if_ram`-style port of the RAM; the other RAM port stays free for an independent user.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥1).
- `RAM_WIDTH`, 18: data width.
- `RAM_DEPTH`, 1024: number of entries; address width `AW = $clog2(RAM_DEPTH)`.
- `RD_LATENCY`, 2: RAM read latency in cycles (2 = output-register mode, 1 = low-latency mode).
- `INIT_ON_RESET`, 1: 1 = zero-fill all entries after reset; 0 = go directly to RUN.

Ports:
- `i_clk`, in, 1: clock. This is the only clock; the block has one clock domain.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_req_val`, in, `NUM_REQ`: per-requester request valid.
- `i_req_we`, in, `NUM_REQ`: 1 = write, 0 = read.
- `i_req_addr`, in, `NUM_REQ*AW`: packed addresses; requester k uses bits `[k*AW +: AW]`.
- `i_req_d`, in, `NUM_REQ*RAM_WIDTH`: packed write data.
- `o_req_rdy`, out, `NUM_REQ`: grant, at most one bit set.
- `o_rsp_val`, out, `NUM_REQ`: one-hot read-response valid.
- `o_rsp_q`, out, `RAM_WIDTH`: read data, shared by all requesters.
- `o_ram_a`, out, `AW`: RAM port address.
- `o_ram_en`, out, 1: RAM port enable.
- `o_ram_we`, out, 1: RAM port write enable.
- `o_ram_re`, out, 1: RAM port output-register enable.
- `o_ram_d`, out, `RAM_WIDTH`: RAM port write data.
- `i_ram_q`, in, `RAM_WIDTH`: RAM port read data.
- `o_init_done`, out, 1: high once the zero-fill is complete (or immediately if `INIT_ON_RESET` = 0).

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT if `INIT_ON_RESET` = 1, else RUN.
- INIT:
  - A counter `cnt` runs from 0 to `RAM_DEPTH-1`, one write per cycle: `o_ram_en` = 1, `o_ram_we` = 1, `o_ram_a` = `cnt`, `o_ram_d` = 0.
  - All `o_req_rdy` bits are 0 throughout INIT.
  - After the write to `RAM_DEPTH-1` is issued, the FSM moves to RUN and `o_init_done` goes to 1. The counter does not assume `RAM_DEPTH` is a power of 2.
- RUN, arbitration:
  - A registered pointer `ptr` (reset value 0) selects the first requester to check.
  - The grant `g` is the first k with `i_req_val[k]` = 1, searching upward from `ptr` with wrap-around.
  - `o_req_rdy` = one-hot(g), driven combinationally from `i_req_val` and `ptr`. It is all zeros if no request is valid.
  - A request is accepted when `i_req_val[g]` and `o_req_rdy[g]` are both 1. On accept, `ptr` becomes `(g+1) mod NUM_REQ`. With no accept, `ptr` holds.
- RAM port outputs are registered:
  - The cycle after an accept: `o_ram_en` = 1, `o_ram_we` = `i_req_we[g]`, `o_ram_a` and `o_ram_d` = requester g's fields.
  - The cycle after no accept: `o_ram_en` = 0 and `o_ram_we` = 0; `o_ram_a` and `o_ram_d` hold their previous values.
- Read tracking:
  - A shift register of depth `RD_LATENCY` carries {valid, one-hot id} for each issued read. Writes enter the shift register as invalid.
  - When an entry leaves the last stage, `o_rsp_val` = its one-hot id and `o_rsp_q` = `i_ram_q`.
  - If `RD_LATENCY` = 2: `o_ram_re` = stage-1 valid, i.e. it is high the cycle after a read is driven on the RAM port. If `RD_LATENCY` = 1: `o_ram_re` = 0.
- Responses cannot be back-pressured. Requesters must accept `o_rsp_val` unconditionally.
- Reads and writes issue in accept order, so a read accepted after a write to the same address returns the new data.

## Timing
- Reset values: `o_req_rdy` = 0, `o_rsp_val` = 0, `o_ram_en` = 0, `o_ram_we` = 0, `o_ram_re` = 0, `o_ram_a` = 0, `o_ram_d` = 0, `o_init_done` = 0, `ptr` = 0, shift register all invalid.
- INIT timing: the first zero-write (address 0) is on the RAM port in the first cycle after `i_rst` deasserts. The last write (address `RAM_DEPTH-1`) is in cycle `RAM_DEPTH`. `o_init_done` and the first possible `o_req_rdy` are in cycle `RAM_DEPTH+1`.
- Read latency: accept in cycle t → RAM port driven in t+1 → `o_rsp_val` in t+1+`RD_LATENCY` (t+3 by default).
- Throughput: one accept per cycle. A single requester holding `val` is granted every cycle. With k requesters continuously valid, each one is granted exactly once every k cycles.
- Reset mid-operation: all in-flight reads are dropped, so no `o_rsp_val` appears after reset. INIT restarts from address 0.
- Simultaneous read response and new accept: both proceed independently; no stalls.

## Test plan
- `INIT_ON_RESET` = 1, `RAM_DEPTH` = 16: release reset → `o_ram_we` = 1 with addresses 0..15 on cycles 1..16, `o_init_done` = 1 on cycle 17, then a read of any address returns 0.
- Requester 2 writes 0x2A5 to address 7, then requester 0 reads address 7 in the next cycle → `o_rsp_val` = 4'b0001 and `o_rsp_q` = 0x2A5, exactly 3 cycles after the read is accepted.
- All 4 requesters hold `val` with reads of addresses 0..3 → grants go 0,1,2,3,0,…, and responses return with matching one-hot ids in the same order.
- Only requester 3 valid for 10 cycles → 10 consecutive grants, then 10 consecutive responses with `o_rsp_val` = 4'b1000 each.
- Assert `i_rst` for one cycle while 2 reads are in flight → no `o_rsp_val` afterwards, and INIT restarts at address 0.
- `RD_LATENCY` = 1, `INIT_ON_RESET` = 0 → `o_init_done` = 1 the cycle after reset, read response 2 cycles after accept, `o_ram_re` stays 0.
